// File: rtl/fixed_point_accumulate.sv
// Sums a group of sign-magnitude products plus a bias into one saturated sign-magnitude result.
// Optional macro FXP_ACC_RELU_EN clamps negative results to zero at the output.
module fixed_point_accumulate #(
   parameter int BITSIZE   = 16,
   parameter int FRAC_BITS = 8,
   parameter int MAX_TERMS = 64,
   localparam int CNT_W    = $clog2(MAX_TERMS + 1)
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               in_valid,
   output logic               in_ready,
   input  logic [BITSIZE-1:0] in_data,
   input  logic               in_last,
   input  logic [BITSIZE-1:0] bias,
   output logic               out_valid,
   input  logic               out_ready,
   output logic [BITSIZE-1:0] out_data,
   output logic               out_sat,
   output logic [CNT_W-1:0]   out_count
);
   localparam int ACC_W = BITSIZE + $clog2(MAX_TERMS) + 1;
   localparam int MAG_W = BITSIZE - 1;

   // The binary point is only a labelling convention; it just has to fit in the word.
   if (FRAC_BITS >= BITSIZE) begin : g_bad_frac
      $error("FRAC_BITS must be smaller than BITSIZE");
   end

   typedef enum logic {S_ACC, S_OUT} state_t;

   state_t                    state_q, state_d;
   logic signed [ACC_W-1:0]   acc_q, acc_d;
   logic [CNT_W-1:0]          cnt_q, cnt_d;
   logic                      first_q, first_d;
   logic                      out_valid_q, out_valid_d;
   logic [BITSIZE-1:0]        out_data_q, out_data_d;
   logic                      out_sat_q, out_sat_d;
   logic [CNT_W-1:0]          out_count_q, out_count_d;

   logic signed [ACC_W-1:0]   sum;
   logic [CNT_W-1:0]          cnt_nxt;
   logic                      neg, sat;
   logic [ACC_W-1:0]          mag;
   logic [MAG_W-1:0]          mag_clip;

   function automatic logic signed [ACC_W-1:0] sm2tc(input logic [BITSIZE-1:0] v);
      logic signed [ACC_W-1:0] m;
      m = $signed({{(ACC_W-MAG_W){1'b0}}, v[MAG_W-1:0]});
      return v[BITSIZE-1] ? -m : m;
   endfunction

   assign in_ready  = (state_q == S_ACC);
   assign out_valid = out_valid_q;
   assign out_data  = out_data_q;
   assign out_sat   = out_sat_q;
   assign out_count = out_count_q;

   always_comb begin
      sum      = (first_q ? sm2tc(bias) : acc_q) + sm2tc(in_data);
      cnt_nxt  = first_q ? CNT_W'(1) : cnt_q + CNT_W'(1);
      neg      = sum[ACC_W-1];
      mag      = neg ? $unsigned(-sum) : $unsigned(sum);
      sat      = (mag > {{(ACC_W-MAG_W){1'b0}}, {MAG_W{1'b1}}});
      mag_clip = sat ? {MAG_W{1'b1}} : mag[MAG_W-1:0];

      state_d     = state_q;
      acc_d       = acc_q;
      cnt_d       = cnt_q;
      first_d     = first_q;
      out_valid_d = out_valid_q;
      out_data_d  = out_data_q;
      out_sat_d   = out_sat_q;
      out_count_d = out_count_q;

      case (state_q)
         S_ACC: begin
            if (in_valid) begin
               acc_d   = sum;
               cnt_d   = cnt_nxt;
               first_d = 1'b0;
               // A full group closes on its own even without in_last.
               if (in_last || cnt_nxt == CNT_W'(MAX_TERMS)) begin
                  state_d     = S_OUT;
                  out_valid_d = 1'b1;
                  out_count_d = cnt_nxt;
`ifdef FXP_ACC_RELU_EN
                  out_data_d  = neg ? '0 : {1'b0, mag_clip};
                  out_sat_d   = neg ? 1'b0 : sat;
`else
                  out_data_d  = {neg, mag_clip};
                  out_sat_d   = sat;
`endif
               end
            end
         end
         S_OUT: begin
            if (out_ready) begin
               state_d     = S_ACC;
               first_d     = 1'b1;
               out_valid_d = 1'b0;
            end
         end
         default: state_d = S_ACC;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q     <= S_ACC;
         acc_q       <= '0;
         cnt_q       <= '0;
         first_q     <= 1'b1;
         out_valid_q <= 1'b0;
         out_data_q  <= '0;
         out_sat_q   <= 1'b0;
         out_count_q <= '0;
      end else begin
         state_q     <= state_d;
         acc_q       <= acc_d;
         cnt_q       <= cnt_d;
         first_q     <= first_d;
         out_valid_q <= out_valid_d;
         out_data_q  <= out_data_d;
         out_sat_q   <= out_sat_d;
         out_count_q <= out_count_d;
      end
   end
endmodule

// File: tb/tb_fixed_point_accumulate.sv
// Self-checking bench: directed vector table, hand sequences and a random run against a sum model.
module tb_fixed_point_accumulate;
   logic        clk = 1'b0;
   logic        rst_n;
   logic        in_valid, in_last, out_ready;
   logic        in_ready, out_valid, out_sat;
   logic [15:0] in_data, bias, out_data;
   logic [6:0]  out_count;

   // Small instance for the forced group end at MAX_TERMS=4.
   logic        v4, l4, ordy4, rdy4, ov4, os4;
   logic [15:0] d4, b4, od4;
   logic [2:0]  oc4;

   int pass_cnt = 0;
   int total    = 0;

   always #5 clk = ~clk;

   fixed_point_accumulate dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
      .in_data(in_data), .in_last(in_last), .bias(bias), .out_valid(out_valid),
      .out_ready(out_ready), .out_data(out_data), .out_sat(out_sat), .out_count(out_count)
   );

   fixed_point_accumulate #(.MAX_TERMS(4)) dut4 (
      .clk(clk), .rst_n(rst_n), .in_valid(v4), .in_ready(rdy4),
      .in_data(d4), .in_last(l4), .bias(b4), .out_valid(ov4),
      .out_ready(ordy4), .out_data(od4), .out_sat(os4), .out_count(oc4)
   );

   typedef struct {
      string       name;
      logic [15:0] b;
      int          n;
      logic [15:0] d [4];
      logic [15:0] exp_data;
      logic        exp_sat;
      int          exp_cnt;
   } vec_t;

   vec_t vecs [6];

   task automatic chk(input string name, input longint act, input longint exp);
      total++;
      if (act == exp) pass_cnt++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
   endtask

   function automatic int smv(input logic [15:0] v);
      int m;
      m = int'(v[14:0]);
      return v[15] ? -m : m;
   endfunction

   // Reference formatting from the integer sum.
   function automatic void fmt(input int s, output logic [15:0] d, output logic sat);
      int m;
      m   = (s < 0) ? -s : s;
      sat = (m > 32767);
      d   = {(s < 0), sat ? 15'h7fff : m[14:0]};
`ifdef FXP_ACC_RELU_EN
      if (s < 0) begin
         d   = 16'h0000;
         sat = 1'b0;
      end
`endif
   endfunction

   task automatic beat(input logic [15:0] d, input logic last, input logic [15:0] b);
      in_valid = 1'b1; in_data = d; in_last = last; bias = b;
      @(posedge clk); #1;
      in_valid = 1'b0; in_last = 1'b0;
   endtask

   task automatic release_out(input string name);
      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
      chk({name, " out_valid after handshake"}, out_valid, 0);
      chk({name, " in_ready after handshake"}, in_ready, 1);
   endtask

   task automatic chk_result(input string name, input logic [15:0] ed, input logic es, input int ec);
      chk({name, " out_valid"}, out_valid, 1);
      chk({name, " out_data"}, out_data, ed);
      chk({name, " out_sat"}, out_sat, es);
      chk({name, " out_count"}, out_count, ec);
      chk({name, " in_ready"}, in_ready, 0);
   endtask

   task automatic beat4(input logic [15:0] d, input logic last);
      v4 = 1'b1; d4 = d; l4 = last; b4 = 16'h0000;
      @(posedge clk); #1;
      v4 = 1'b0; l4 = 1'b0;
   endtask

   initial begin
      logic [15:0] ed;
      logic        es;
      int          sum, cnt, n, gap;
      logic [15:0] d, b;
      logic        last;

      vecs[0] = '{"basic", 16'h0000, 3, '{16'h0100, 16'h0080, 16'h8080, 16'h0}, 16'h0100, 1'b0, 3};
      vecs[1] = '{"sat_pos", 16'h7F00, 1, '{16'h7F00, 16'h0, 16'h0, 16'h0}, 16'h7FFF, 1'b1, 1};
`ifdef FXP_ACC_RELU_EN
      vecs[2] = '{"sat_neg", 16'hFF00, 1, '{16'hFF00, 16'h0, 16'h0, 16'h0}, 16'h0000, 1'b0, 1};
      vecs[3] = '{"neg", 16'h8100, 1, '{16'h8080, 16'h0, 16'h0, 16'h0}, 16'h0000, 1'b0, 1};
`else
      vecs[2] = '{"sat_neg", 16'hFF00, 1, '{16'hFF00, 16'h0, 16'h0, 16'h0}, 16'hFFFF, 1'b1, 1};
      vecs[3] = '{"neg", 16'h8100, 1, '{16'h8080, 16'h0, 16'h0, 16'h0}, 16'h8180, 1'b0, 1};
`endif
      vecs[4] = '{"negzero", 16'h8000, 1, '{16'h8000, 16'h0, 16'h0, 16'h0}, 16'h0000, 1'b0, 1};
      vecs[5] = '{"cancel", 16'h0010, 2, '{16'h0020, 16'h8030, 16'h0, 16'h0}, 16'h0000, 1'b0, 2};

      rst_n = 1'b0; in_valid = 1'b0; in_last = 1'b0; in_data = '0; bias = '0; out_ready = 1'b0;
      v4 = 1'b0; l4 = 1'b0; d4 = '0; b4 = '0; ordy4 = 1'b0;
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
      chk("reset out_valid", out_valid, 0);
      chk("reset out_data", out_data, 0);
      chk("reset out_sat", out_sat, 0);
      chk("reset out_count", out_count, 0);
      chk("reset in_ready", in_ready, 1);

      for (int i = 0; i < 6; i++) begin
         for (int k = 0; k < vecs[i].n; k++) beat(vecs[i].d[k], k == vecs[i].n - 1, vecs[i].b);
         chk_result(vecs[i].name, vecs[i].exp_data, vecs[i].exp_sat, vecs[i].exp_cnt);
         release_out(vecs[i].name);
      end

      // Backpressure: offered beats must be ignored while the result is held.
      beat(16'h0100, 1'b0, 16'h0000);
      beat(16'h0080, 1'b0, 16'h0000);
      beat(16'h8080, 1'b1, 16'h0000);
      in_valid = 1'b1; in_data = 16'h7000; in_last = 1'b1; bias = 16'h0100;
      for (int c = 0; c < 5; c++) begin
         @(posedge clk); #1;
         chk("bp out_valid", out_valid, 1);
         chk("bp out_data", out_data, 16'h0100);
         chk("bp in_ready", in_ready, 0);
      end
      in_valid = 1'b0; in_last = 1'b0;
      release_out("bp");
      beat(16'h0100, 1'b1, 16'h0000);
      chk_result("bp next", 16'h0100, 1'b0, 1);
      release_out("bp next");

      // Reset in the middle of a group drops the partial sum.
      beat(16'h0100, 1'b0, 16'h0200);
      beat(16'h0300, 1'b0, 16'h0000);
      rst_n = 1'b0;
      @(posedge clk); #1;
      rst_n = 1'b1;
      chk("rst mid out_valid", out_valid, 0);
      chk("rst mid in_ready", in_ready, 1);
      beat(16'h0080, 1'b1, 16'h0000);
      chk_result("rst mid next", 16'h0080, 1'b0, 1);
      release_out("rst mid next");

      // Random groups; bias changes every beat, only the first-beat value may count.
      for (int g = 0; g < 40; g++) begin
         n   = (g == 15) ? 70 : int'($urandom_range(1, 8));
         sum = 0;
         cnt = 0;
         for (int k = 0; k < n; k++) begin
            if ($urandom_range(0, 3) == 0) begin
               in_valid = 1'b0; in_last = 1'($urandom); in_data = 16'($urandom);
               @(posedge clk); #1;
               in_last = 1'b0;
            end
            d = 16'($urandom);
            if ($urandom_range(0, 1) == 1) d[14:9] = '0;
            b = 16'($urandom);
            b[14:10] = '0;
            last = (k == n - 1);
            if (cnt == 0) sum = smv(b);
            sum += smv(d);
            cnt++;
            beat(d, last, b);
            if (last || cnt == 64) begin
               fmt(sum, ed, es);
               chk_result($sformatf("rand g%0d", g), ed, es, cnt);
               gap = int'($urandom_range(0, 2));
               repeat (gap) @(posedge clk);
               #1;
               release_out($sformatf("rand g%0d", g));
               break;
            end else begin
               chk($sformatf("rand g%0d busy", g), out_valid, 0);
            end
         end
      end

      // MAX_TERMS=4: four beats without in_last close the group; the fifth opens a new one.
      for (int k = 0; k < 4; k++) beat4(16'h0100, 1'b0);
      chk("max4 out_valid", ov4, 1);
      chk("max4 out_data", od4, 16'h0400);
      chk("max4 out_count", oc4, 4);
      ordy4 = 1'b1;
      @(posedge clk); #1;
      ordy4 = 1'b0;
      beat4(16'h0100, 1'b0);
      chk("max4 fifth pending", ov4, 0);
      beat4(16'h0100, 1'b1);
      chk("max4 second out_data", od4, 16'h0200);
      chk("max4 second out_count", oc4, 2);

      $display("%0d/%0d checks passed", pass_cnt, total);
      $finish;
   end
endmodule
